// File: rtl/keypad_pkg.sv
// Shared keypad definitions: special key codes, scanner states and the matrix keymap.
package keypad_pkg;

  localparam logic [3:0] KEY_CLR   = 4'hD;
  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN0,
    ST_SCAN1,
    ST_SCAN2,
    ST_SCAN3,
    ST_PRESSED,
    ST_WAIT_REL
  } scan_state_t;

  // Lowest active (low) row index wins when several rows are pulled down.
  function automatic logic [3:0] keymap(input logic [1:0] c, input logic [3:0] row);
    logic [1:0] r;
    if (!row[0])      r = 2'd0;
    else if (!row[1]) r = 2'd1;
    else if (!row[2]) r = 2'd2;
    else              r = 2'd3;
    case ({c, r})
      4'h0:    return 4'h1;
      4'h1:    return 4'h4;
      4'h2:    return 4'h7;
      4'h3:    return KEY_BKSP;
      4'h4:    return 4'h2;
      4'h5:    return 4'h5;
      4'h6:    return 4'h8;
      4'h7:    return 4'h0;
      4'h8:    return 4'h3;
      4'h9:    return 4'h6;
      4'hA:    return 4'h9;
      4'hB:    return KEY_ENTER;
      4'hC:    return 4'hA;
      4'hD:    return 4'hB;
      4'hE:    return 4'hC;
      default: return KEY_CLR;
    endcase
  endfunction

endpackage

// File: rtl/keypad_entry_buffer_scanner.sv
// Keypad matrix scanner: tick divider, column scan FSM and press/release debounce.
// state       | meaning
// ST_IDLE     | all columns driven, waiting for any row low
// ST_SCAN0..3 | one column driven low, looking for the pressed column
// ST_PRESSED  | confirming the latched key over DEBOUNCE ticks
// ST_WAIT_REL | event sent, waiting for DEBOUNCE released ticks
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV_W = 20,
  parameter int DEBOUNCE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam logic [2:0] DEB_LAST = 3'(DEBOUNCE - 1);

  logic [SCAN_DIV_W-1:0] div;
  logic                  tick;
  scan_state_t           state;
  scan_state_t           scan_next;
  logic [1:0]            scan_idx;
  logic [1:0]            lat_col;
  logic [3:0]            lat_row;
  logic [2:0]            deb;

  assign tick = &div;

  always_comb begin
    scan_next = ST_IDLE;
    scan_idx  = 2'd0;
    case (state)
      ST_SCAN0: begin scan_next = ST_SCAN1; scan_idx = 2'd0; end
      ST_SCAN1: begin scan_next = ST_SCAN2; scan_idx = 2'd1; end
      ST_SCAN2: begin scan_next = ST_SCAN3; scan_idx = 2'd2; end
      ST_SCAN3: begin scan_next = ST_IDLE;  scan_idx = 2'd3; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      state     <= ST_IDLE;
      col       <= 4'h0;
      lat_col   <= 2'd0;
      lat_row   <= 4'hF;
      deb       <= 3'd0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      div       <= div + SCAN_DIV_W'(1);
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_IDLE: begin
            if (row != 4'hF) begin
              state <= ST_SCAN0;
              col   <= 4'b1110;
            end
          end
          ST_SCAN0, ST_SCAN1, ST_SCAN2, ST_SCAN3: begin
            if (row != 4'hF) begin
              // col keeps driving the hit column through PRESSED/WAIT_REL
              state   <= ST_PRESSED;
              lat_col <= scan_idx;
              lat_row <= row;
              deb     <= 3'd0;
            end else begin
              state <= scan_next;
              col   <= (state == ST_SCAN3) ? 4'h0 : {col[2:0], 1'b1};
            end
          end
          ST_PRESSED: begin
            if (row == lat_row) begin
              if (deb == DEB_LAST) begin
                state <= ST_WAIT_REL;
                deb   <= 3'd0;
                if (en) begin
                  key_valid <= 1'b1;
                  key_code  <= keymap(lat_col, lat_row);
                end
              end else begin
                deb <= deb + 3'd1;
              end
            end else begin
              state <= ST_IDLE;
              col   <= 4'h0;
            end
          end
          ST_WAIT_REL: begin
            if (row == 4'hF) begin
              if (deb == DEB_LAST) begin
                state <= ST_IDLE;
                col   <= 4'h0;
              end else begin
                deb <= deb + 3'd1;
              end
            end else begin
              deb <= 3'd0;
            end
          end
          default: begin
            state <= ST_IDLE;
            col   <= 4'h0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad front end: scanner plus a DEPTH-digit entry buffer with backspace, clear
// and a valid/ready commit port that freezes the buffer until the entry is taken.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int SCAN_DIV_W = 20,
  parameter int DEBOUNCE   = 2,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         row,
  output logic [3:0]         col,
  output logic               key_valid,
  output logic [3:0]         key_code,
  output logic [4*DEPTH-1:0] digits,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               overflow,
  output logic               commit_valid,
  input  logic               commit_ready,
  output logic [4*DEPTH-1:0] commit_data,
  output logic [CW-1:0]      commit_len
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [3:0] mem [DEPTH];

  keypad_scanner #(
    .SCAN_DIV_W(SCAN_DIV_W),
    .DEBOUNCE  (DEBOUNCE)
  ) u_scanner (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always_comb begin
    digits = '0;
    for (int i = 0; i < DEPTH; i++) digits[4*i +: 4] = mem[i];
  end

  assign full = (count == DEPTH_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h0;
      count        <= '0;
      overflow     <= 1'b0;
      commit_valid <= 1'b0;
      commit_data  <= '0;
      commit_len   <= '0;
    end else begin
      overflow <= 1'b0;
      // A key event landing while an entry is pending is dropped, including the handshake cycle.
      if (commit_valid) begin
        if (commit_ready) begin
          commit_valid <= 1'b0;
          count        <= '0;
          for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h0;
        end
      end else if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (count < DEPTH_C) begin
            for (int i = 0; i < DEPTH; i++)
              if (CW'(i) == count) mem[i] <= key_code;
            count <= count + CW'(1);
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          case (key_code)
            KEY_BKSP: begin
              if (count != '0) begin
                for (int i = 0; i < DEPTH; i++)
                  if (CW'(i) == count - CW'(1)) mem[i] <= 4'h0;
                count <= count - CW'(1);
              end
            end
            KEY_CLR: begin
              count <= '0;
              for (int i = 0; i < DEPTH; i++) mem[i] <= 4'h0;
            end
            KEY_ENTER: begin
              if (count != '0) begin
                commit_valid <= 1'b1;
                commit_data  <= digits;
                commit_len   <= count;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Parametrised 4x4 matrix-keypad scanner with debounced key events and a DEPTH-entry digit buffer that supports backspace, clear and a committed-entry handshake. It replaces the fixed 8-digit keypad front end. It sits between the board keypad pins and the game/evaluation logic, which consumes whole entries over a valid/ready port. Seven-segment encoding and result scoring are done downstream from the 4-bit digit codes.

## Interface
- DEPTH, 8: number of digit entries held (1..16).
- SCAN_DIV_W, 20: scan tick period is 2^SCAN_DIV_W clk cycles (about 21 ms at 50 MHz).
- DEBOUNCE, 2: number of consecutive identical scan samples required to accept a press or a release (1..7).
- CW: local constant, $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  when low, key events are not applied to the buffer and key_valid is suppressed; scanning continues.
- row  in  4  keypad rows, active-low.
- col  out  4  keypad column drive, active-low.
- key_valid  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key (held).
- digits  out  4*DEPTH  entry i is at [4i+3:4i]; unused entries read 0.
- count  out  CW  number of digits stored.
- full  out  1  count == DEPTH.
- overflow  out  1  one-cycle pulse when a digit is dropped because the buffer is full.
- commit_valid  out  1  committed entry available.
- commit_ready  in  1  consumer accepts the entry.
- commit_data  out  4*DEPTH  snapshot of digits at commit.
- commit_len  out  CW  snapshot of count at commit.

## Operation
- Key map (col scanned index c, row index r): c0: 1,4,7,BKSP; c1: 2,5,8,0; c2: 3,6,9,ENTER; c3: A,B,C,CLR. Digit codes are 0-9, A/B/C are 10-12, CLR=0xD, BKSP=0xE, ENTER=0xF.
- Scanner FSM, which advances only on scan ticks:
  - IDLE: col=0000. Goes to SCAN0 when row != F.
  - SCANn (n=0..3): col drives only bit n low. If row != F, go to PRESSED and latch {n, row}; otherwise go to SCAN(n+1). SCAN3 with no key returns to IDLE.
  - PRESSED: re-sample the latched column. After DEBOUNCE identical samples, emit one event and go to WAIT_REL. If the sample changes or goes to F, return to IDLE without an event.
  - WAIT_REL: after DEBOUNCE consecutive samples with row==F, go to IDLE.
  - There is no autorepeat. When several rows are low, the lowest row index wins; among columns, the lowest scanned column wins.
- Buffer actions per event, applied only if en=1 and commit_valid=0 (otherwise the event is dropped):
  - Digit: if count<DEPTH, write digits[count] and increment count. Otherwise pulse overflow.
  - BKSP: if count>0, decrement count and zero that entry. At count 0 it is a no-op.
  - CLR: count=0 and all entries are zeroed.
  - ENTER: if count>0, load commit_data/commit_len and set commit_valid. At count 0 it is ignored.
  - A/B/C: reported on key_code only; not stored.
- Commit handshake: commit_valid stays high and commit_data/commit_len stay stable until commit_valid && commit_ready. On the handshake, commit_valid clears, count=0 and digits are zeroed. The buffer stays frozen while commit_valid=1.

## Timing
- Scan tick: a free-running SCAN_DIV_W-bit counter produces a 1-cycle enable when it wraps. There is no derived clock; all logic is on clk.
- key_valid and key_code update on the clk edge following the tick that completes debounce.
- digits/count/full/overflow/commit_valid update one clk after the key_valid cycle.
- commit_valid falls one clk after the handshake cycle. An event arriving in the handshake cycle is dropped.
- Reset values: col=0000, key_valid=0, key_code=0, digits=0, count=0, full=0, overflow=0, commit_valid=0, commit_data=0, commit_len=0, FSM=IDLE, tick counter=0.
- Reset mid-press or mid-commit discards everything. A key still held after reset produces a new event after a full scan plus debounce.

## Structure
- Package keypad_pkg holds the KEY_CLR/KEY_BKSP/KEY_ENTER constants, the scan-state enum, and the keymap function (col index, row) -> code.
- Sub-module keypad_scanner contains the tick counter, the FSM and debounce, and outputs key_valid/key_code. The top level contains the buffer and the commit logic.

## Test plan
Use SCAN_DIV_W=4, DEBOUNCE=2, DEPTH=8.
- Press 1,2,3 (row pattern for c0r0, c1r0, c2r0), release each -> key_valid pulses 3 times; count=3; digits[11:0]=0x321.
- 9 digit presses -> count=8, full=1; the 9th press pulses overflow and the buffer is unchanged.
- Enter 4,5 then BKSP, BKSP, BKSP -> count 2,1,0,0; digits=0 at end; no overflow.
- Enter 7,8 then ENTER with commit_ready=0 for 20 cycles -> commit_valid=1, commit_len=2, commit_data[7:0]=0x87 held; a press of 9 is ignored. Raise ready -> commit_valid=0 and count=0 next cycle.
- Row glitch shorter than 2 ticks -> no key_valid. Key held for 50 ticks -> exactly one key_valid.
- Assert rst while commit_valid=1 and a key is held -> all outputs at reset values; after release and re-press, normal operation resumes.
